// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and default sizing.
package mul_div_unit_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_REG_AW = 5;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIVQ) || (op == OP_DIVR);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add for multiply, restoring subtract for divide.
// {hi, lo} is the shared working pair: product halves, or remainder/quotient.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? a : {WIDTH{1'b0}})};
        shifted = {hi, lo[WIDTH-1]};
        // Partial remainder stays below b, so the difference always fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - b;
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, b}) begin
                hi_next = diff;
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Fixed-latency unsigned multiply/divide unit writing its result into a register bank.
// Handshake: start is taken only when busy=0; the result appears with a one-cycle done pulse.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs_out,
    input  logic [WIDTH-1:0]  rt_out,
    input  logic [REG_AW-1:0] dest,
    output logic              busy,
    output logic              done,
    output logic              regWrite,
    output logic [REG_AW-1:0] writeReg,
    output logic [WIDTH-1:0]  writeData,
    output logic              div_by_zero,
    output logic [1:0]        state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_e            state, state_next;
    op_e               op_q;
    logic [WIDTH-1:0]  a_q, b_q, hi_q, lo_q;
    logic [WIDTH-1:0]  hi_next, lo_next, result;
    logic [REG_AW-1:0] dest_q, write_reg;
    logic [WIDTH-1:0]  write_data;
    logic [CW-1:0]     cnt;
    logic              dbz_q;
    logic              load, step_en, finish, is_div;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .a       (a_q),
        .b       (b_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // CALC runs WIDTH step cycles plus one cycle latching the result registers.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CALC;
                    load       = 1'b1;
                end
            end
            ST_CALC: begin
                if (cnt == LAST) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        is_div = op_is_div(op_q);
        case (op_q)
            OP_MULLO: result = lo_q;
            OP_MULHI: result = hi_q;
            OP_DIVQ:  result = lo_q;
            default:  result = hi_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MULLO;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dest_q     <= '0;
            cnt        <= '0;
            write_reg  <= '0;
            write_data <= '0;
            dbz_q      <= 1'b0;
        end else if (load) begin
            op_q   <= op_e'(op);
            a_q    <= rs_out;
            b_q    <= rt_out;
            dest_q <= dest;
            cnt    <= '0;
            hi_q   <= '0;
            // lo starts as the dividend for divide, the multiplier for multiply.
            lo_q   <= op[1] ? rs_out : rt_out;
        end else if (step_en) begin
            hi_q <= hi_next;
            lo_q <= lo_next;
            cnt  <= cnt + 1'b1;
        end else if (finish) begin
            write_data <= result;
            write_reg  <= dest_q;
            dbz_q      <= is_div && (b_q == '0);
        end
    end

    assign busy        = (state == ST_CALC) || (state == ST_DONE);
    assign done        = (state == ST_DONE);
    assign regWrite    = done && (dest_q != '0);
    assign div_by_zero = done && dbz_q;
    assign writeReg    = write_reg;
    assign writeData   = write_data;
    assign state_dbg   = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, divide-by-zero, start blocking
// and mid-operation reset.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_out, rt_out;
    logic [4:0]  dest;
    logic        busy, done, regWrite, div_by_zero;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rw_cnt = 0;
    int done_base, rw_base;

    mul_div_unit #(.WIDTH(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_out      (rs_out),
        .rt_out      (rt_out),
        .dest        (dest),
        .busy        (busy),
        .done        (done),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1)     done_cnt++;
        if (regWrite === 1'b1) rw_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp, input logic exp_dbz);
        op = o; rs_out = a; rt_out = b; dest = d; start = 1'b1;
        tick();
        start = 1'b0;
        rs_out = $urandom; rt_out = $urandom; dest = 5'($urandom_range(0, 31));
        check({tag, " busy_after_start"}, busy, 1'b1);
        repeat (32) tick();
        check({tag, " done_not_early"}, done, 1'b0);
        tick();
        check({tag, " done"}, done, 1'b1);
        check({tag, " regWrite"}, regWrite, (d != 5'd0));
        check({tag, " writeReg"}, writeReg, d);
        check({tag, " writeData"}, writeData, exp);
        check({tag, " div_by_zero"}, div_by_zero, exp_dbz);
        tick();
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " idle_busy"}, busy, 1'b0);
        check({tag, " data_held"}, writeData, exp);
        check({tag, " dbz_low_idle"}, div_by_zero, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_out = '0; rt_out = '0; dest = '0;
        repeat (3) tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset regWrite", regWrite, 1'b0);
        check("reset writeReg", writeReg, 5'd0);
        check("reset writeData", writeData, 32'd0);
        check("reset dbz", div_by_zero, 1'b0);
        check("reset state", state_dbg, ST_IDLE);
        rst = 1'b0;

        run_op("mulhi", 2'b01, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0001, 1'b0);
        run_op("mullo", 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0000, 1'b0);
        run_op("divq", 2'b10, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
        run_op("divr", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 1'b0);
        run_op("divq_zero", 2'b10, 32'h0000_1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1);
        run_op("divr_zero", 2'b11, 32'h0000_1234, 32'd0, 5'd6, 32'h0000_1234, 1'b1);
        run_op("mullo_dest0", 2'b00, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0);
        run_op("mulhi_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 1'b0);
        run_op("mullo_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0);
        run_op("divq_by1", 2'b10, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 1'b0);
        run_op("divr_by1", 2'b11, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0, 1'b0);
        run_op("divq_small", 2'b10, 32'd7, 32'd100, 5'd8, 32'd0, 1'b0);
        run_op("divr_small", 2'b11, 32'd7, 32'd100, 5'd8, 32'd7, 1'b0);

        // Extra starts during CALC (edge 5) and across the DONE cycle must be ignored.
        done_base = done_cnt; rw_base = rw_cnt;
        op = 2'b00; rs_out = 32'd6; rt_out = 32'd7; dest = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b01; rs_out = 32'd99; rt_out = 32'd99; dest = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        op = 2'b10; rs_out = 32'd50; rt_out = 32'd5; dest = 5'd10; start = 1'b1;
        tick();
        check("block done", done, 1'b1);
        check("block writeData", writeData, 32'd42);
        check("block writeReg", writeReg, 5'd3);
        tick();
        start = 1'b0;
        check("block no_requeue", busy, 1'b0);
        repeat (40) tick();
        check("block done_pulses", done_cnt - done_base, 1);
        check("block regWrite_pulses", rw_cnt - rw_base, 1);
        check("block data_held", writeData, 32'd42);

        // Asynchronous reset in the middle of CALC.
        op = 2'b10; rs_out = 32'd1000; rt_out = 32'd3; dest = 5'd12; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort writeData", writeData, 32'd0);
        done_base = done_cnt; rw_base = rw_cnt;
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("abort no_done", done_cnt - done_base, 0);
        check("abort no_regWrite", rw_cnt - rw_base, 0);
        run_op("after_abort", 2'b10, 32'd1000, 32'd3, 5'd12, 32'd333, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
